// File: rtl/cpu_core_top_if.sv
// Host-side bus of cpu_core_top: memory load port, run control, stall control and trace.
`default_nettype none

interface cpu_core_top_if;
    logic [31:0]  cpu_write_addr_in;
    logic [31:0]  cpu_write_data_in;
    logic [31:0]  cpu_write_enable_in;
    logic [31:0]  cpu_ctrl_in;
    logic         stall_enable_in;
    logic         stall_disable_in;
    logic         is_stall_enabled_out;
    logic [127:0] iana_out;

    modport master (
        output cpu_write_addr_in, cpu_write_data_in, cpu_write_enable_in, cpu_ctrl_in,
               stall_enable_in, stall_disable_in,
        input  is_stall_enabled_out, iana_out
    );

    modport slave (
        input  cpu_write_addr_in, cpu_write_data_in, cpu_write_enable_in, cpu_ctrl_in,
               stall_enable_in, stall_disable_in,
        output is_stall_enabled_out, iana_out
    );
endinterface

`default_nettype wire

// File: rtl/cpu_core_top.sv
// ============================================================================
// cpu_core_top : single-cycle 32-bit CPU, unified word memory, 128-bit trace.
// Optional feature macro: CPU_IRQ_EN (edge-triggered interrupt on ctrl[11]).
// Rev 1.0
// ============================================================================
`default_nettype none

module cpu_core_top #(
    parameter int          MEM_WORDS  = 1024,
    parameter logic [31:0] IRQ_VECTOR = 32'h10
) (
    input  wire logic     clk,
    input  wire logic     rst,
    cpu_core_top_if.slave bus
);
    localparam int AW = $clog2(MEM_WORDS);

    logic [31:0]  mem [MEM_WORDS];
    logic [31:0]  regs [16];
    logic [31:0]  pc;
    logic         halted;
    logic         stall_flag;
    logic         soft_prev;
    logic [23:0]  retire_cnt;
    logic [127:0] iana;

    logic         soft_rst, halt_req, active, irq_take;
    logic [31:0]  instr, imm, rv1, rv2, mem_addr, lw_data;
    logic [3:0]   op, rd, rs1, rs2;

    assign soft_rst = bus.cpu_ctrl_in[0];
    assign halt_req = bus.cpu_ctrl_in[12];
    assign active   = !soft_rst && !halt_req && !stall_flag && !halted;

    assign instr    = mem[pc[AW-1:0]];
    assign op       = instr[31:28];
    assign rd       = instr[27:24];
    assign rs1      = instr[23:20];
    assign rs2      = instr[19:16];
    assign imm      = {{16{instr[15]}}, instr[15:0]};
    assign rv1      = (rs1 == 4'd0) ? 32'd0 : regs[rs1];
    assign rv2      = (rs2 == 4'd0) ? 32'd0 : regs[rs2];
    assign mem_addr = rv1 + imm;
    assign lw_data  = mem[mem_addr[AW-1:0]];

`ifdef CPU_IRQ_EN
    logic irq_sample, irq_pending, irq_rise;
    logic unused_bits;
    assign irq_rise = bus.cpu_ctrl_in[11] && !irq_sample;
    assign irq_take = active && (irq_rise || irq_pending);

    // An edge seen while inactive waits in irq_pending until the core runs again
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            irq_sample  <= 1'b0;
            irq_pending <= 1'b0;
        end else begin
            irq_sample  <= bus.cpu_ctrl_in[11];
            irq_pending <= (irq_pending || irq_rise) && !irq_take;
        end
    end
    assign unused_bits = ^{bus.cpu_write_enable_in[31:4], bus.cpu_ctrl_in[31:13],
                           bus.cpu_ctrl_in[10:1], mem_addr[31:AW]};
`else
    logic unused_bits;
    assign irq_take    = 1'b0;
    assign unused_bits = ^{bus.cpu_write_enable_in[31:4], bus.cpu_ctrl_in[31:11],
                           bus.cpu_ctrl_in[10:1], mem_addr[31:AW]};
`endif

    logic [31:0] result, next_pc, data;
    logic        wb, is_sw, is_br, is_halt;
    logic        retire, regwr, store, br_taken, halt_set;
    logic [23:0] cnt_next;
    logic [7:0]  flags;

    always_comb begin
        result  = 32'd0;
        next_pc = pc + 32'd1;
        wb      = 1'b0;
        is_sw   = 1'b0;
        is_br   = 1'b0;
        is_halt = 1'b0;
        case (op)
            4'h1: begin result = rv1 + rv2;          wb = 1'b1; end
            4'h2: begin result = rv1 - rv2;          wb = 1'b1; end
            4'h3: begin result = rv1 & rv2;          wb = 1'b1; end
            4'h4: begin result = rv1 | rv2;          wb = 1'b1; end
            4'h5: begin result = rv1 ^ rv2;          wb = 1'b1; end
            4'h6: begin result = rv1 + imm;          wb = 1'b1; end
            4'h7: begin result = {imm[15:0], 16'd0}; wb = 1'b1; end
            4'h8: begin result = lw_data;            wb = 1'b1; end
            4'h9: is_sw = 1'b1;
            4'hA: begin
                if (rv1 == rv2) begin
                    next_pc = pc + imm;
                    is_br   = 1'b1;
                end
            end
            4'hB: begin
                result  = pc + 32'd1;
                wb      = 1'b1;
                next_pc = pc + imm;
                is_br   = 1'b1;
            end
            4'hF: begin
                is_halt = 1'b1;
                next_pc = pc;
            end
            default: ;
        endcase

        retire   = active && !irq_take;
        regwr    = retire && wb && (rd != 4'd0);
        store    = retire && is_sw;
        br_taken = retire && is_br;
        halt_set = retire && is_halt;
        data     = regwr ? result : (store ? rv2 : 32'd0);
        cnt_next = retire_cnt + {23'd0, retire};
        flags    = {soft_prev, stall_flag, halted || halt_set, irq_take,
                    br_taken, store, regwr, retire};
    end

    // Trace stays zero while soft reset is held; softrst marks the first word after release
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc         <= 32'd0;
            halted     <= 1'b0;
            stall_flag <= 1'b0;
            soft_prev  <= 1'b0;
            retire_cnt <= 24'd0;
            iana       <= 128'd0;
            for (int i = 0; i < 16; i++) regs[i] <= 32'd0;
        end else begin
            soft_prev <= soft_rst;
            if (bus.stall_disable_in)     stall_flag <= 1'b0;
            else if (bus.stall_enable_in) stall_flag <= 1'b1;

            if (soft_rst) begin
                pc         <= 32'd0;
                halted     <= 1'b0;
                retire_cnt <= 24'd0;
                iana       <= 128'd0;
            end else begin
                if (irq_take) begin
                    regs[15] <= pc;
                    pc       <= IRQ_VECTOR;
                end else if (retire) begin
                    pc <= next_pc;
                    if (regwr)    regs[rd] <= result;
                    if (halt_set) halted   <= 1'b1;
                end
                retire_cnt <= cnt_next;
                iana       <= {pc, instr, data, cnt_next, flags};
            end
        end
    end

    // Host lanes are written after the store so they win on a shared word
    always_ff @(posedge clk) begin
        if (store && !rst) mem[mem_addr[AW-1:0]] <= rv2;
        for (int b = 0; b < 4; b++) begin
            if (bus.cpu_write_enable_in[b])
                mem[bus.cpu_write_addr_in[AW-1:0]][8*b +: 8] <= bus.cpu_write_data_in[8*b +: 8];
        end
    end

    assign bus.iana_out             = iana;
    assign bus.is_stall_enabled_out = stall_flag;

endmodule

`default_nettype wire

// File: tb/tb_cpu_core_top.sv
// Directed self-checking bench for cpu_core_top.
`default_nettype none

module tb_cpu_core_top;
    logic clk = 1'b0;
    logic rst = 1'b0;
    int   checks = 0;
    int   failures = 0;

    cpu_core_top_if bus();
    cpu_core_top dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load_word(input logic [31:0] addr, input logic [31:0] data,
                             input logic [3:0] lanes);
        bus.cpu_write_addr_in   = addr;
        bus.cpu_write_data_in   = data;
        bus.cpu_write_enable_in = {28'd0, lanes};
        tick();
        bus.cpu_write_enable_in = 32'd0;
    endtask

    task automatic test_reset();
        bus.cpu_write_addr_in   = 32'd0;
        bus.cpu_write_data_in   = 32'd0;
        bus.cpu_write_enable_in = 32'd0;
        bus.cpu_ctrl_in         = 32'd1;
        bus.stall_enable_in     = 1'b0;
        bus.stall_disable_in    = 1'b0;
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        for (int i = 0; i < 16; i++) begin
            tick();
            checks++;
            if (bus.iana_out !== 128'd0 || bus.is_stall_enabled_out !== 1'b0) begin
                failures++;
                $display("FAIL reset_hold cyc=%0d iana=%h stall=%b required iana=0 stall=0",
                         i, bus.iana_out, bus.is_stall_enabled_out);
            end
        end
    endtask

    task automatic test_program();
        logic [127:0] exp_tr [5];
        exp_tr[0] = {32'h0, 32'h61000005, 32'h5, 24'd1, 8'h83};
        exp_tr[1] = {32'h1, 32'h62100003, 32'h8, 24'd2, 8'h03};
        exp_tr[2] = {32'h2, 32'h90020040, 32'h8, 24'd3, 8'h05};
        exp_tr[3] = {32'h3, 32'hF0000000, 32'h0, 24'd4, 8'h21};
        exp_tr[4] = {32'h3, 32'hF0000000, 32'h0, 24'd4, 8'h20};
        load_word(32'h0, 32'h61000005, 4'hF);
        load_word(32'h1, 32'h62100003, 4'hF);
        load_word(32'h2, 32'h90020040, 4'hF);
        load_word(32'h3, 32'hF0000000, 4'hF);
        load_word(32'h50, 32'hAABBCCDD, 4'hF);
        load_word(32'h50, 32'h11223344, 4'b0101);
        checks++;
        if (dut.mem[32'h50] !== 32'hAA22CC44) begin
            failures++;
            $display("FAIL byte_lanes got=%h required=%h", dut.mem[32'h50], 32'hAA22CC44);
        end
        bus.cpu_ctrl_in = 32'd0;
        for (int i = 0; i < 5; i++) begin
            tick();
            checks++;
            if (bus.iana_out !== exp_tr[i]) begin
                failures++;
                $display("FAIL prog_trace step=%0d got=%h required=%h", i, bus.iana_out, exp_tr[i]);
            end
        end
        checks++;
        if (dut.mem[32'h40] !== 32'd8) begin
            failures++;
            $display("FAIL sw_mem got=%h required=%h", dut.mem[32'h40], 32'd8);
        end
    endtask

    task automatic test_halt_ctrl();
        logic [31:0] exp_pc [6];
        logic [31:0] exp_dt [6];
        exp_pc = '{32'd0, 32'd1, 32'd3, 32'd0, 32'd1, 32'd3};
        exp_dt = '{32'd1, 32'd0, 32'd4, 32'd2, 32'd0, 32'd4};
        bus.cpu_ctrl_in = 32'd1;
        load_word(32'h0, 32'h63300001, 4'hF);
        load_word(32'h1, 32'hA0000002, 4'hF);
        load_word(32'h2, 32'hF0000000, 4'hF);
        load_word(32'h3, 32'hB400FFFD, 4'hF);
        bus.cpu_ctrl_in = 32'd0;
        for (int i = 0; i < 6; i++) begin
            tick();
            checks++;
            if (bus.iana_out[127:96] !== exp_pc[i] || bus.iana_out[63:32] !== exp_dt[i] ||
                bus.iana_out[31:8] !== 24'(i + 1) || bus.iana_out[0] !== 1'b1) begin
                failures++;
                $display("FAIL loop step=%0d got pc=%h data=%h cnt=%0d ret=%b required pc=%h data=%h cnt=%0d ret=1",
                         i, bus.iana_out[127:96], bus.iana_out[63:32], bus.iana_out[31:8],
                         bus.iana_out[0], exp_pc[i], exp_dt[i], i + 1);
            end
        end
        bus.cpu_ctrl_in = 32'h1000;
        for (int i = 0; i < 5; i++) begin
            tick();
            checks++;
            if (bus.iana_out[127:96] !== 32'd0 || bus.iana_out[0] !== 1'b0 ||
                bus.iana_out[63:32] !== 32'd0 || bus.iana_out[31:8] !== 24'd6) begin
                failures++;
                $display("FAIL halt_hold step=%0d got pc=%h ret=%b data=%h cnt=%0d required pc=0 ret=0 data=0 cnt=6",
                         i, bus.iana_out[127:96], bus.iana_out[0], bus.iana_out[63:32], bus.iana_out[31:8]);
            end
        end
        bus.cpu_ctrl_in = 32'd0;
        tick();
        checks++;
        if (bus.iana_out[127:96] !== 32'd0 || bus.iana_out[63:32] !== 32'd3 ||
            bus.iana_out[31:8] !== 24'd7) begin
            failures++;
            $display("FAIL halt_resume got pc=%h data=%h cnt=%0d required pc=0 data=3 cnt=7",
                     bus.iana_out[127:96], bus.iana_out[63:32], bus.iana_out[31:8]);
        end
        tick();
        checks++;
        if (bus.iana_out[127:96] !== 32'd1 || bus.iana_out[31:8] !== 24'd8) begin
            failures++;
            $display("FAIL halt_resume2 got pc=%h cnt=%0d required pc=1 cnt=8",
                     bus.iana_out[127:96], bus.iana_out[31:8]);
        end
    endtask

    task automatic test_stall();
        logic [31:0] exp_pc [4];
        logic [31:0] exp_dt [4];
        exp_pc = '{32'd0, 32'd1, 32'd3, 32'd0};
        exp_dt = '{32'd4, 32'd0, 32'd4, 32'd5};
        bus.stall_enable_in = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            checks++;
            if (bus.is_stall_enabled_out !== 1'b1 || bus.iana_out[0] !== (i == 0) ||
                bus.iana_out[127:96] !== ((i == 0) ? 32'd3 : 32'd0)) begin
                failures++;
                $display("FAIL stall_on step=%0d got flag=%b ret=%b pc=%h required flag=1 ret=%b pc=%h",
                         i, bus.is_stall_enabled_out, bus.iana_out[0], bus.iana_out[127:96],
                         (i == 0), (i == 0) ? 32'd3 : 32'd0);
            end
        end
        bus.stall_enable_in  = 1'b0;
        bus.stall_disable_in = 1'b1;
        tick();
        checks++;
        if (bus.is_stall_enabled_out !== 1'b0 || bus.iana_out[0] !== 1'b0 ||
            bus.iana_out[6] !== 1'b1) begin
            failures++;
            $display("FAIL stall_off got flag=%b ret=%b stallbit=%b required flag=0 ret=0 stallbit=1",
                     bus.is_stall_enabled_out, bus.iana_out[0], bus.iana_out[6]);
        end
        for (int i = 0; i < 4; i++) begin
            tick();
            checks++;
            if (bus.is_stall_enabled_out !== 1'b0 || bus.iana_out[127:96] !== exp_pc[i] ||
                bus.iana_out[63:32] !== exp_dt[i] || bus.iana_out[0] !== 1'b1) begin
                failures++;
                $display("FAIL stall_resume step=%0d got flag=%b pc=%h data=%h required flag=0 pc=%h data=%h",
                         i, bus.is_stall_enabled_out, bus.iana_out[127:96], bus.iana_out[63:32],
                         exp_pc[i], exp_dt[i]);
            end
        end
        bus.stall_disable_in = 1'b0;
        bus.stall_enable_in  = 1'b1;
        tick();
        bus.stall_disable_in = 1'b1;
        tick();
        checks++;
        if (bus.is_stall_enabled_out !== 1'b0 || bus.iana_out[0] !== 1'b0) begin
            failures++;
            $display("FAIL stall_both got flag=%b ret=%b required flag=0 ret=0",
                     bus.is_stall_enabled_out, bus.iana_out[0]);
        end
        bus.stall_enable_in  = 1'b0;
        bus.stall_disable_in = 1'b0;
    endtask

    task automatic test_irq();
        int irq_seen;
        bus.cpu_ctrl_in = 32'd1;
        load_word(32'h10, 32'h65500001, 4'hF);
        load_word(32'h11, 32'hF0000000, 4'hF);
        bus.cpu_ctrl_in = 32'd0;
        tick();
        tick();
        bus.cpu_ctrl_in = 32'h800;
        irq_seen = 0;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (bus.iana_out[4] === 1'b1) irq_seen++;
`ifdef CPU_IRQ_EN
            if (i == 0) begin
                checks++;
                if (bus.iana_out[127:96] !== 32'd3 || bus.iana_out[4] !== 1'b1 ||
                    bus.iana_out[0] !== 1'b0) begin
                    failures++;
                    $display("FAIL irq_take got pc=%h irq=%b ret=%b required pc=3 irq=1 ret=0",
                             bus.iana_out[127:96], bus.iana_out[4], bus.iana_out[0]);
                end
            end
            if (i == 1) begin
                checks++;
                if (bus.iana_out[127:96] !== 32'h10) begin
                    failures++;
                    $display("FAIL irq_vector got pc=%h required pc=10", bus.iana_out[127:96]);
                end
            end
`endif
        end
        bus.cpu_ctrl_in = 32'd0;
`ifdef CPU_IRQ_EN
        checks++;
        if (irq_seen != 1 || dut.regs[15] !== 32'd3) begin
            failures++;
            $display("FAIL irq_once got irqs=%0d r15=%h required irqs=1 r15=3", irq_seen, dut.regs[15]);
        end
`else
        checks++;
        if (irq_seen != 0) begin
            failures++;
            $display("FAIL irq_disabled got irqs=%0d required irqs=0", irq_seen);
        end
`endif
    endtask

    task automatic test_async_reset();
        bus.cpu_ctrl_in = 32'd1;
        tick();
        bus.cpu_ctrl_in = 32'd0;
        tick();
        tick();
        bus.stall_enable_in = 1'b1;
        tick();
        bus.stall_enable_in = 1'b0;
        checks++;
        if (bus.is_stall_enabled_out !== 1'b1 || bus.iana_out === 128'd0) begin
            failures++;
            $display("FAIL pre_async got flag=%b iana=%h required flag=1 iana nonzero",
                     bus.is_stall_enabled_out, bus.iana_out);
        end
        rst = 1'b1;
        #2;
        checks++;
        if (bus.iana_out !== 128'd0 || bus.is_stall_enabled_out !== 1'b0) begin
            failures++;
            $display("FAIL async_rst got iana=%h flag=%b required iana=0 flag=0",
                     bus.iana_out, bus.is_stall_enabled_out);
        end
        tick();
        rst = 1'b0;
    endtask

    initial begin
        test_reset();
        test_program();
        test_halt_ctrl();
        test_stall();
        test_irq();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout got=running required=finished");
        $fatal(1, "timeout");
    end

endmodule

`default_nettype wire
